// File: rtl/calc_sequencer.sv
// calc_sequencer: two-operand keypad calculator sequencer driving an external ALU and a 4-digit BCD display.
module calc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  key_code,
  input  logic        key_valid,
  output logic [6:0]  alu_a,
  output logic [6:0]  alu_b,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [13:0] alu_result,
  output logic        busy,
  output logic [15:0] disp
);
  typedef enum logic [3:0] {IDLE, A1, A2, OPR, B1, B2, CALC, CONV, SHOW, ERR} state_t;
  state_t state, nxt;
  logic [3:0] a_hi, a_lo, b_hi, b_lo, cnt;
  logic [1:0] op;
  logic start;
  logic [13:0] bin;
  logic [15:0] bcd, bcd_adj, disp_r, show;
  logic is_dig, is_op, is_clr, is_eq, err_sub, ovf, z3, z2, z1;
  assign is_dig = key_valid && key_code < 8'd10;
  assign is_op = key_valid && (key_code == 8'h80 || key_code == 8'h81 || key_code == 8'h82);
  assign is_clr = key_valid && key_code == 8'h8E;
  assign is_eq = key_valid && key_code == 8'h8F;
  // operands are kept as decimal digits so entry display needs no conversion
  assign alu_a = {a_hi, 3'b000} + {2'b00, a_hi, 1'b0} + {3'b000, a_lo};
  assign alu_b = {b_hi, 3'b000} + {2'b00, b_hi, 1'b0} + {3'b000, b_lo};
  assign alu_op = op;
  assign alu_start = start;
  assign busy = state == CALC || state == CONV;
  assign err_sub = op == 2'b01 && alu_a < alu_b;
  assign ovf = alu_result > 14'd9999;
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign bcd_adj[4*i +: 4] = bcd[4*i +: 4] > 4'd4 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  assign z3 = bcd[15:12] == 4'd0;
  assign z2 = z3 && bcd[11:8] == 4'd0;
  assign z1 = z2 && bcd[7:4] == 4'd0;
  assign show = {z3 ? 4'hF : bcd[15:12], z2 ? 4'hF : bcd[11:8], z1 ? 4'hF : bcd[7:4], bcd[3:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (is_clr) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = is_dig ? A1 : IDLE;
        A1:      nxt = is_dig ? A2 : is_op ? OPR : A1;
        A2:      nxt = is_op ? OPR : A2;
        OPR:     nxt = is_dig ? B1 : OPR;
        B1:      nxt = is_dig ? B2 : is_eq ? (err_sub ? ERR : CALC) : B1;
        B2:      nxt = is_eq ? (err_sub ? ERR : CALC) : B2;
        CALC:    nxt = alu_done ? (ovf ? ERR : CONV) : CALC;
        CONV:    nxt = cnt == 4'd13 ? SHOW : CONV;
        SHOW:    nxt = is_dig ? A1 : SHOW;
        default: nxt = state;
      endcase
  end
  always_comb begin
    disp = 16'hFFFF;
    case (state)
      A1:        disp = {12'hFFF, a_lo};
      A2, OPR:   disp = {8'hFF, a_hi, a_lo};
      B1:        disp = {12'hFFF, b_lo};
      B2:        disp = {8'hFF, b_hi, b_lo};
      CALC, CONV: disp = disp_r;
      SHOW:      disp = show;
      ERR:       disp = 16'hFFFE;
      default:   disp = 16'hFFFF;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_hi <= '0;
      a_lo <= '0;
      b_hi <= '0;
      b_lo <= '0;
      op <= '0;
      start <= 1'b0;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      disp_r <= 16'hFFFF;
    end else begin
      start <= nxt == CALC && state != CALC;
      disp_r <= disp;
      if (is_clr) begin
        a_hi <= '0;
        a_lo <= '0;
        b_hi <= '0;
        b_lo <= '0;
        op <= '0;
      end else begin
        if (is_dig && (state == IDLE || state == SHOW)) begin
          a_hi <= '0;
          a_lo <= key_code[3:0];
        end
        if (is_dig && state == A1) begin
          a_hi <= a_lo;
          a_lo <= key_code[3:0];
        end
        if (is_op && (state == A1 || state == A2 || state == OPR)) op <= key_code[1:0];
        if (is_dig && state == OPR) begin
          b_hi <= '0;
          b_lo <= key_code[3:0];
        end
        if (is_dig && state == B1) begin
          b_hi <= b_lo;
          b_lo <= key_code[3:0];
        end
        if (state == CALC && nxt == CONV) begin
          bin <= alu_result;
          bcd <= '0;
          cnt <= '0;
        end
        if (state == CONV) begin
          bcd <= {bcd_adj[14:0], bin[13]};
          bin <= {bin[12:0], 1'b0};
          cnt <= cnt + 4'd1;
        end
      end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: vector table plus corner-case sequences, ALU operands checked against a queue of expected starts.
module tb_calc_sequencer;
  localparam logic [7:0] ADD = 8'h80, SUB = 8'h81, MUL = 8'h82, CLR = 8'h8E, EQ = 8'h8F;
  logic clk = 1'b0, rst = 1'b1, key_valid = 1'b0, alu_done = 1'b0;
  logic [7:0] key_code = '0;
  logic [13:0] alu_result = '0;
  logic [6:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic alu_start, busy;
  logic [15:0] disp;
  calc_sequencer dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy), .disp(disp)
  );
  always #5 clk = ~clk;
  typedef struct packed { logic [6:0] a; logic [6:0] b; logic [1:0] op; } txn_t;
  typedef struct packed {
    logic [63:0] keys;
    logic [3:0]  nk;
    logic [13:0] res;
    logic        st;
    txn_t        t;
    logic [15:0] disp;
  } vec_t;
  int tests = 0, fails = 0, start_cnt = 0, base;
  txn_t exp_q[$];
  txn_t lat, e;
  bit in_calc = 1'b0, ok;
  vec_t v[12];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  // operand snapshot at each start, then hold check until done or abandonment
  always @(posedge clk) begin
    #1;
    if (alu_start) begin
      start_cnt++;
      if (exp_q.size() == 0) chk("unexpected_start", 16'd1, 16'd0);
      else begin
        e = exp_q.pop_front();
        chk("start_operands", {alu_a, alu_b, alu_op}, e);
      end
      lat = {alu_a, alu_b, alu_op};
      in_calc = 1'b1;
    end else if (in_calc && busy) chk("operand_hold", {alu_a, alu_b, alu_op}, lat);
    if (alu_done || !busy) in_calc = 1'b0;
  end
  task automatic press(input logic [7:0] k);
    key_code = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_code = '0;
  endtask
  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_start(input int b, output bit got);
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (start_cnt != b) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic done_pulse(input logic [13:0] r);
    alu_result = r;
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
  endtask
  function automatic vec_t mk(input logic [63:0] k, input int n, input int r, input bit s,
                              input int a, input int b, input int o, input logic [15:0] d);
    vec_t x;
    x.keys = k;
    x.nk = 4'(n);
    x.res = 14'(r);
    x.st = s;
    x.t = {7'(a), 7'(b), 2'(o)};
    x.disp = d;
    return x;
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    v[0]  = mk({8'h04, 8'h02, ADD, 8'h01, 8'h07, EQ, 16'h0}, 6, 59, 1, 42, 17, 0, 16'hFF59);
    v[1]  = mk({8'h09, 8'h09, MUL, 8'h09, 8'h09, EQ, 16'h0}, 6, 9801, 1, 99, 99, 2, 16'h9801);
    v[2]  = mk({8'h03, SUB, 8'h05, EQ, 32'h0}, 4, 0, 0, 0, 0, 0, 16'hFFFE);
    v[3]  = mk({8'h01, 8'h02, 8'h03, ADD, SUB, 8'h04, EQ, 8'h0}, 7, 8, 1, 12, 4, 1, 16'hFFF8);
    v[4]  = mk({8'h05, ADD, 8'h00, EQ, 32'h0}, 4, 5, 1, 5, 0, 0, 16'hFFF5);
    v[5]  = mk({8'h07, MUL, 8'h00, EQ, 32'h0}, 4, 0, 1, 7, 0, 2, 16'hFFF0);
    v[6]  = mk({8'h05, 8'h00, SUB, 8'h05, 8'h00, EQ, 16'h0}, 6, 0, 1, 50, 50, 1, 16'hFFF0);
    v[7]  = mk({8'h02, ADD, 8'h03, EQ, 32'h0}, 4, 10000, 1, 2, 3, 0, 16'hFFFE);
    v[8]  = mk({8'h05, 8'h00, MUL, 8'h02, 8'h00, EQ, 16'h0}, 6, 1000, 1, 50, 20, 2, 16'h1000);
    v[9]  = mk({8'h06, 8'h0A, ADD, EQ, 8'h03, EQ, 16'h0}, 6, 9, 1, 6, 3, 0, 16'hFFF9);
    v[10] = mk({8'h01, 8'h00, SUB, 8'h01, 8'h01, EQ, 16'h0}, 6, 0, 0, 0, 0, 0, 16'hFFFE);
    v[11] = mk({8'h08, ADD, 8'h04, 8'h05, 8'h06, EQ, 16'h0}, 6, 53, 1, 8, 45, 0, 16'hFF53);
    @(negedge clk);
    chk("rst_disp", disp, 16'hFFFF);
    chk("rst_outs", {alu_a, alu_b, alu_op}, 16'h0);
    chk("rst_start_busy", {14'd0, alu_start, busy}, 16'h0);
    rst = 1'b0;
    waitn(1);
    for (int i = 0; i < 12; i++) begin
      press(CLR);
      chk($sformatf("v%0d_clear", i), disp, 16'hFFFF);
      base = start_cnt;
      if (v[i].st) exp_q.push_back(v[i].t);
      for (int k = 0; k < int'(v[i].nk); k++) press(v[i].keys[63-8*k -: 8]);
      wait_start(base, ok);
      chk($sformatf("v%0d_start_seen", i), 16'(ok), 16'(v[i].st));
      if (ok && v[i].st) begin
        done_pulse(v[i].res);
        waitn(13);
        chk($sformatf("v%0d_busy_last_conv", i), 16'(busy), 16'(v[i].res <= 14'd9999));
        waitn(1);
        chk($sformatf("v%0d_busy_after", i), 16'(busy), 16'd0);
      end else if (!ok) exp_q.delete();
      chk($sformatf("v%0d_disp", i), disp, v[i].disp);
      chk($sformatf("v%0d_start_pulses", i), 16'(start_cnt - base), 16'(v[i].st));
    end
    press(CLR);
    press(8'h01); chk("entry_a1", disp, 16'hFFF1);
    press(8'h02); chk("entry_a2", disp, 16'hFF12);
    press(8'h03); chk("entry_a_limit", disp, 16'hFF12);
    press(ADD);   chk("entry_opr", disp, 16'hFF12);
    press(8'h04); chk("entry_b1", disp, 16'hFFF4);
    press(8'h05); chk("entry_b2", disp, 16'hFF45);
    press(8'h06); chk("entry_b_limit", disp, 16'hFF45);
    press(CLR);   chk("entry_clear", disp, 16'hFFFF);
    base = start_cnt;
    exp_q.push_back({7'd42, 7'd17, 2'd0});
    press(8'h04); press(8'h02); press(ADD); press(8'h01); press(8'h07); press(EQ);
    wait_start(base, ok);
    chk("show_start_now", {14'd0, alu_start, busy}, 16'h3);
    done_pulse(14'd59);
    waitn(13);
    chk("show_hold_conv", disp, 16'hFF17);
    waitn(1);
    chk("show_result", disp, 16'hFF59);
    chk("show_one_start", 16'(start_cnt - base), 16'd1);
    press(ADD);   chk("show_op_ignored", disp, 16'hFF59);
    press(8'h07); chk("show_new_a1", disp, 16'hFFF7);
    press(8'h03); chk("show_new_a2", disp, 16'hFF73);
    press(CLR);
    base = start_cnt;
    press(8'h03); press(SUB); press(8'h05); press(EQ);
    waitn(2);
    chk("err_disp", disp, 16'hFFFE);
    press(8'h05); chk("err_digit", disp, 16'hFFFE);
    press(EQ);    chk("err_equal", disp, 16'hFFFE);
    chk("err_no_start", 16'(start_cnt - base), 16'd0);
    press(CLR);   chk("err_clear", disp, 16'hFFFF);
    press(8'h02); chk("err_idle_after", disp, 16'hFFF2);
    press(CLR);
    base = start_cnt;
    exp_q.push_back({7'd4, 7'd5, 2'd0});
    press(8'h04); press(ADD); press(8'h05); press(EQ);
    wait_start(base, ok);
    chk("calc_clr_started", 16'(ok), 16'd1);
    press(CLR);
    chk("calc_clr_disp", disp, 16'hFFFF);
    chk("calc_clr_busy", 16'(busy), 16'd0);
    done_pulse(14'd9);
    waitn(16);
    chk("calc_clr_late_done", disp, 16'hFFFF);
    chk("calc_clr_late_busy", 16'(busy), 16'd0);
    base = start_cnt;
    exp_q.push_back({7'd4, 7'd5, 2'd0});
    press(8'h04); press(ADD); press(8'h05); press(EQ);
    wait_start(base, ok);
    waitn(2);
    alu_result = 14'd9;
    alu_done = 1'b1;
    key_code = CLR;
    key_valid = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    key_valid = 1'b0;
    chk("clr_wins_disp", disp, 16'hFFFF);
    chk("clr_wins_busy", 16'(busy), 16'd0);
    waitn(15);
    chk("clr_wins_later", disp, 16'hFFFF);
    press(CLR);
    base = start_cnt;
    exp_q.push_back({7'd99, 7'd99, 2'd2});
    press(8'h09); press(8'h09); press(MUL); press(8'h09); press(8'h09); press(EQ);
    wait_start(base, ok);
    done_pulse(14'd9801);
    waitn(5);
    chk("rst_mid_busy_before", 16'(busy), 16'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_disp", disp, 16'hFFFF);
    chk("rst_mid_outs", {alu_a, alu_b, alu_op}, 16'h0);
    chk("rst_mid_start_busy", {14'd0, alu_start, busy}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    base = start_cnt;
    done_pulse(14'd77);
    waitn(16);
    chk("rst_late_done_disp", disp, 16'hFFFF);
    chk("rst_late_done_busy", 16'(busy), 16'd0);
    exp_q.push_back({7'd5, 7'd0, 2'd0});
    press(8'h05); press(ADD); press(8'h00); press(EQ);
    wait_start(base, ok);
    chk("rst_fresh_start", 16'(ok), 16'd1);
    done_pulse(14'd5);
    waitn(14);
    chk("rst_fresh_disp", disp, 16'hFFF5);
    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: key_code  input  8  key code, valid only while key_valid=1.
REQ-004 SHALL have ports: key_valid  input  1  one-cycle key strobe.
REQ-005 SHALL have ports: alu_a  output  7  operand A, binary 0..99.
REQ-006 SHALL have ports: alu_b  output  7  operand B, binary 0..99.
REQ-007 SHALL have ports: alu_op  output  2  operation: 00 add, 01 sub, 10 mul.
REQ-008 SHALL have ports: alu_start  output  1  one-cycle start pulse to the arithmetic unit.
REQ-009 SHALL have ports: alu_done  input  1  one-cycle completion pulse.
REQ-010 SHALL have ports: alu_result  input  14  binary result, valid when alu_done=1.
REQ-011 SHALL have ports: busy  output  1  high in CALC and CONV.
REQ-012 SHALL have ports: disp  output  16  four BCD digits, [15:12] most significant; nibble 4'hF = blank, 4'hE = "E".

Function
REQ-013 Key codes SHALL be: 8'h00-8'h09 digits; 8'h80 ADD; 8'h81 SUB; 8'h82 MUL; 8'h8E CLEAR; 8'h8F EQUAL; any other code ignored.
REQ-014 States SHALL be: IDLE, A1, A2, OPR, B1, B2, CALC, CONV, SHOW, ERR; a key strobed in cycle t changes state/registers at edge t+1.
REQ-015 IDLE: digit d -> A1, A=d; other keys ignored.
REQ-016 A1: digit d -> A2, A=10*A+d; operator -> OPR, latch op; others ignored.
REQ-017 A2: operator -> OPR, latch op; digits ignored (two-digit limit); EQUAL ignored.
REQ-018 OPR: digit d -> B1, B=d; new operator overwrites op; EQUAL ignored.
REQ-019 B1: digit -> B2, B=10*B+d; B1/B2 EQUAL -> CALC with alu_start=1 for exactly the first CALC cycle; B2 digits ignored.
REQ-020 EQUAL with op=SUB and A<B SHALL go to ERR without asserting alu_start.
REQ-021 alu_a, alu_b, alu_op SHALL be stable from the alu_start cycle until alu_done.
REQ-022 CALC: on alu_done latch alu_result, go CONV; no timeout; non-CLEAR keys ignored.
REQ-023 CONV SHALL perform serial shift-add-3 binary-to-BCD, one bit per cycle, exactly 14 cycles, then SHOW.
REQ-024 SHOW: disp = result BCD with leading zeros blanked (units digit always shown, 0 -> 16'hFFF0); digit d -> A1 with A=d; other keys ignored.
REQ-025 ERR: disp = 16'hFFFE; only CLEAR leaves.
REQ-026 disp during entry: IDLE 16'hFFFF; A1 {F,F,F,a0}; A2/OPR {F,F,a1,a0}; B1 {F,F,F,b0}; B2 {F,F,b1,b0}; CALC/CONV hold previous value.
REQ-027 CLEAR in any state SHALL go to IDLE next cycle, zero A, B, op, set disp=16'hFFFF.
REQ-028 alu_done outside CALC, including after CLEAR during CALC, SHALL be ignored.
REQ-029 alu_done and CLEAR in the same cycle: CLEAR wins.
REQ-030 alu_result above 9999 SHALL go to ERR instead of CONV.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, alu_a=0, alu_b=0, alu_op=00, alu_start=0, busy=0, disp=16'hFFFF, conversion counter 0.
REQ-032 Reset mid-CALC/CONV SHALL abandon the operation; a later alu_done SHALL be ignored.

Verification
REQ-033 Keys 4,2,ADD,1,7,EQUAL; alu_done with 59 -> one alu_start pulse, alu_a=42, alu_b=17, op=00; disp=16'hFF59 exactly 14 cycles after done.
REQ-034 Keys 9,9,MUL,9,9,EQUAL; result 9801 -> disp=16'h9801; busy high from the start cycle through the last CONV cycle.
REQ-035 Keys 3,SUB,5,EQUAL -> no alu_start, disp=16'hFFFE; CLEAR -> disp=16'hFFFF, state IDLE.
REQ-036 Keys 1,2,3 -> disp=16'hFF12 (third digit ignored); ADD then SUB -> alu_op=01 at start.
REQ-037 EQUAL then CLEAR during CALC, then alu_done -> disp stays 16'hFFFF, busy=0, no CONV.
REQ-038 rst pulse mid-CONV -> all outputs at reset values in the same cycle; a fresh 5,ADD,0,EQUAL with result 5 -> disp=16'hFFF5.
